two_stage_delay_capture: RTL and testbench

- Synthesizable, clocked, parametrised two-stage sample-and-hold delay.
- On a trigger, captures data_i, presents it on b_o after DLY1 cycles, then copies b_o to c_o after a further DLY2 cycles.
- Triggers that arrive while a capture is in flight are dropped and counted; trigger is a strobe or any change of data_i.
- Used as a deterministic event-delay element in datapath and verification fixtures.

---
 rtl/two_stage_delay_capture.sv | 97 +++++++++
 tb/tb_two_stage_delay_capture.sv | 98 +++++++++
 2 files changed

// File: rtl/two_stage_delay_capture.sv
// two_stage_delay_capture: trigger-captured value appears on b_o after DLY1 cycles and on c_o DLY2 cycles later
// Define DLY_PENDING_EN to queue one trigger that arrives while busy instead of dropping it.
module two_stage_delay_capture #(
    parameter int WIDTH     = 6,
    parameter int DLY1      = 10,
    parameter int DLY2      = 8,
    parameter int TRIG_MODE = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             busy_o,
    output logic [WIDTH-1:0] b_o,
    output logic             b_valid_o,
    output logic [WIDTH-1:0] c_o,
    output logic             c_valid_o,
    output logic [CNT_W-1:0] drop_cnt_o
);
    localparam int MAXD = DLY1 > DLY2 ? DLY1 : DLY2;
    localparam int CW   = MAXD > 1 ? $clog2(MAXD) : 1;
    localparam logic [CW-1:0] D1 = CW'(DLY1 - 1);
    localparam logic [CW-1:0] D2 = CW'(DLY2 - 1);
    typedef enum logic [1:0] {IDLE, STAGE1, STAGE2} state_t;
    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hold, r_prev;
    logic             w_trg, w_busy, w_done, w_drop;
`ifdef DLY_PENDING_EN
    logic [WIDTH-1:0] r_pend_data;
    logic             r_pend_vld;
`endif
    assign w_trg  = (TRIG_MODE == 1) ? (data_i != r_prev) : trig_i;
    assign w_busy = r_state != IDLE;
    assign w_done = r_state == STAGE2 && r_cnt == '0;
`ifdef DLY_PENDING_EN
    // Only an overwrite of a full slot loses a trigger; the completion edge frees the slot.
    assign w_drop = w_trg && w_busy && !w_done && r_pend_vld;
`else
    assign w_drop = w_trg && w_busy;
`endif
    assign busy_o = w_busy;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_hold     <= '0;
            r_prev     <= '0;
            b_o        <= '0;
            c_o        <= '0;
            b_valid_o  <= 1'b0;
            c_valid_o  <= 1'b0;
            drop_cnt_o <= '0;
`ifdef DLY_PENDING_EN
            r_pend_data <= '0;
            r_pend_vld  <= 1'b0;
`endif
        end else begin
            r_prev    <= data_i;
            b_valid_o <= 1'b0;
            c_valid_o <= 1'b0;
            if (w_drop && !(&drop_cnt_o)) drop_cnt_o <= drop_cnt_o + 1'b1;
            case (r_state)
                IDLE: if (w_trg) begin
                    r_hold  <= data_i;
                    r_cnt   <= D1;
                    r_state <= STAGE1;
                end
                STAGE1: if (r_cnt == '0) begin
                    b_o       <= r_hold;
                    b_valid_o <= 1'b1;
                    r_cnt     <= D2;
                    r_state   <= STAGE2;
                end else r_cnt <= r_cnt - 1'b1;
                STAGE2: if (w_done) begin
                    c_o       <= b_o;
                    c_valid_o <= 1'b1;
                    r_state   <= IDLE;
`ifdef DLY_PENDING_EN
                    if (r_pend_vld || w_trg) begin
                        r_hold  <= r_pend_vld ? r_pend_data : data_i;
                        r_cnt   <= D1;
                        r_state <= STAGE1;
                    end
`endif
                end else r_cnt <= r_cnt - 1'b1;
                default: r_state <= IDLE;
            endcase
`ifdef DLY_PENDING_EN
            if (w_done) r_pend_vld <= r_pend_vld && w_trg;
            else if (w_trg && w_busy) r_pend_vld <= 1'b1;
            if (w_trg && w_busy) r_pend_data <= data_i;
`endif
        end
    end
endmodule

// File: tb/tb_two_stage_delay_capture.sv
// tb_two_stage_delay_capture: directed checks of four parameter sets of two_stage_delay_capture
module tb_two_stage_delay_capture;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    logic       trig_a = 0, trig_b = 0, trig_c = 0, trig_d = 0;
    logic [5:0] data_a = 0, data_b = 0, data_c = 0, data_d = 0;
    logic       busy_a, bv_a, cv_a, busy_b, bv_b, cv_b, busy_c, bv_c, cv_c, busy_d, bv_d, cv_d;
    logic [5:0] b_a, c_a, b_b, c_b, b_c, c_c, b_d, c_d;
    logic [7:0] drop_a, drop_b, drop_d;
    logic [1:0] drop_c;
    two_stage_delay_capture #(.WIDTH(6), .DLY1(10), .DLY2(8), .TRIG_MODE(0), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .trig_i(trig_a), .data_i(data_a), .busy_o(busy_a), .b_o(b_a),
        .b_valid_o(bv_a), .c_o(c_a), .c_valid_o(cv_a), .drop_cnt_o(drop_a));
    two_stage_delay_capture #(.WIDTH(6), .DLY1(10), .DLY2(8), .TRIG_MODE(1), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .trig_i(trig_b), .data_i(data_b), .busy_o(busy_b), .b_o(b_b),
        .b_valid_o(bv_b), .c_o(c_b), .c_valid_o(cv_b), .drop_cnt_o(drop_b));
    two_stage_delay_capture #(.WIDTH(6), .DLY1(3), .DLY2(3), .TRIG_MODE(0), .CNT_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .trig_i(trig_c), .data_i(data_c), .busy_o(busy_c), .b_o(b_c),
        .b_valid_o(bv_c), .c_o(c_c), .c_valid_o(cv_c), .drop_cnt_o(drop_c));
    two_stage_delay_capture #(.WIDTH(6), .DLY1(1), .DLY2(1), .TRIG_MODE(0), .CNT_W(8)) u_d (
        .clk(clk), .rst_n(rst_n), .trig_i(trig_d), .data_i(data_d), .busy_o(busy_d), .b_o(b_d),
        .b_valid_o(bv_d), .c_o(c_d), .c_valid_o(cv_d), .drop_cnt_o(drop_d));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        step();
        step();
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_b_a", 32'(b_a), 32'd0);
        chk("rst_c_a", 32'(c_a), 32'd0);
        chk("rst_bv_a", 32'(bv_a), 32'd0);
        chk("rst_cv_a", 32'(cv_a), 32'd0);
        chk("rst_drop_a", 32'(drop_a), 32'd0);
        chk("rst_drop_c", 32'(drop_c), 32'd0);
        rst_n = 1'b1;
        for (int e = 0; e < 20; e++) begin
            trig_a = (e == 0 || e == 7 || e == 18);
            data_a = (e == 0) ? 6'h2A : (e == 7) ? 6'h11 : 6'h3F;
            data_b = (e >= 5) ? 6'h06 : 6'h05;
            trig_c = (e < 6);
            data_c = 6'h15;
            trig_d = (e == 0);
            data_d = 6'h2C;
            step();
            chk("a_busy", 32'(busy_a), 32'(e < 18));
            chk("a_bv", 32'(bv_a), 32'(e == 10));
            chk("a_cv", 32'(cv_a), 32'(e == 18));
            chk("a_b", 32'(b_a), (e >= 10) ? 32'h2A : 32'h0);
            chk("a_c", 32'(c_a), (e >= 18) ? 32'h2A : 32'h0);
            chk("a_drop", 32'(drop_a), (e >= 18) ? 32'd2 : (e >= 7) ? 32'd1 : 32'd0);
            chk("b_busy", 32'(busy_b), 32'(e < 18));
            chk("b_bv", 32'(bv_b), 32'(e == 10));
            chk("b_cv", 32'(cv_b), 32'(e == 18));
            chk("b_c", 32'(c_b), (e >= 18) ? 32'h05 : 32'h0);
            chk("b_drop", 32'(drop_b), 32'(e >= 5));
            chk("c_drop", 32'(drop_c), (e >= 3) ? 32'd3 : 32'(e));
            chk("c_busy", 32'(busy_c), 32'(e < 6));
            chk("d_busy", 32'(busy_d), 32'(e < 2));
            chk("d_bv", 32'(bv_d), 32'(e == 1));
            chk("d_cv", 32'(cv_d), 32'(e == 2));
            chk("d_b", 32'(b_d), (e >= 1) ? 32'h2C : 32'h0);
            chk("d_c", 32'(c_d), (e >= 2) ? 32'h2C : 32'h0);
        end
        trig_a = 1'b1;
        data_a = 6'h1B;
        step();
        trig_a = 1'b0;
        chk("abort_busy_start", 32'(busy_a), 32'd1);
        repeat (4) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_b", 32'(b_a), 32'd0);
        chk("abort_c", 32'(c_a), 32'd0);
        chk("abort_drop", 32'(drop_a), 32'd0);
        chk("abort_drop_c", 32'(drop_c), 32'd0);
        for (int e = 0; e < 15; e++) begin
            step();
            chk("abort_no_bv", 32'(bv_a), 32'd0);
            chk("abort_idle", 32'(busy_a), 32'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
